// File: rtl/rf_access_ctrl_pkg.sv
// Shared types and defaults for the register-file access controller.
// The optional zf/cf flags are enabled by defining RF_ACCESS_CTRL_FLAGS_EN.
package rf_access_ctrl_pkg;

    localparam int DW = 8;
    localparam int AW = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_LDI = 3'd6,
        OP_NOP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Every opcode except NOP produces a new result and a register write.
    function automatic logic writesBack(input opcode_t op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Request/response bus from decode and the register-file port bus.
// zf/cf exist on the request bus only when RF_ACCESS_CTRL_FLAGS_EN is defined.
interface rf_req_if #(
    parameter int DW = rf_access_ctrl_pkg::DW,
    parameter int AW = rf_access_ctrl_pkg::AW
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_rs0;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rd;
    logic [DW-1:0] req_imm;
    logic          done;
    logic [DW-1:0] result;
`ifdef RF_ACCESS_CTRL_FLAGS_EN
    logic          zf;
    logic          cf;

    modport master (
        output req_valid, req_op, req_rs0, req_rs1, req_rd, req_imm,
        input  req_ready, done, result, zf, cf
    );
    modport slave (
        input  req_valid, req_op, req_rs0, req_rs1, req_rd, req_imm,
        output req_ready, done, result, zf, cf
    );
`else
    modport master (
        output req_valid, req_op, req_rs0, req_rs1, req_rd, req_imm,
        input  req_ready, done, result
    );
    modport slave (
        input  req_valid, req_op, req_rs0, req_rs1, req_rd, req_imm,
        output req_ready, done, result
    );
`endif
endinterface

interface rf_port_if #(
    parameter int DW = rf_access_ctrl_pkg::DW,
    parameter int AW = rf_access_ctrl_pkg::AW
);
    logic [AW-1:0] src0;
    logic [AW-1:0] src1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          we;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;

    modport master (
        output src0, src1, we, dst, data,
        input  data0, data1
    );
    modport slave (
        input  src0, src1, we, dst, data,
        output data0, data1
    );
endinterface

// File: rtl/rf_access_ctrl_alu.sv
// Purely combinational 8-bit ALU used in the EXEC step of rf_access_ctrl.
// o_carry is carry-out for ADD and borrow for SUB, zero otherwise.
module rf_access_alu
    import rf_access_ctrl_pkg::*;
(
    input  opcode_t       i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_imm,
    output logic [DW-1:0] o_result,
    output logic          o_carry
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    // The extra top bit of the difference is set exactly when a < b.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        unique case (i_op)
            OP_ADD: begin
                o_result = w_sum[DW-1:0];
                o_carry  = w_sum[DW];
            end
            OP_SUB: begin
                o_result = w_diff[DW-1:0];
                o_carry  = w_diff[DW];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_MOV:  o_result = i_a;
            OP_LDI:  o_result = i_imm;
            OP_NOP:  o_result = i_a;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Sequencer that reads two registers, computes via rf_access_alu and writes one back.
// Define RF_ACCESS_CTRL_FLAGS_EN to add the registered zf/cf result flags.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    rf_req_if.slave    req,
    rf_port_if.master  rf
);

    state_t        r_state;
    opcode_t       r_op;
    logic [AW-1:0] r_src0;
    logic [AW-1:0] r_src1;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_opA;
    logic [DW-1:0] r_opB;
    logic          r_we;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_data;
    logic          r_done;
    logic [DW-1:0] r_result;
    logic [DW-1:0] w_aluResult;
`ifdef RF_ACCESS_CTRL_FLAGS_EN
    logic          r_zf;
    logic          r_cf;
    logic          w_aluCarry;
`else
    logic          w_unusedCarry;
`endif

    rf_access_alu u_alu (
        .i_op     (r_op),
        .i_a      (r_opA),
        .i_b      (r_opB),
        .i_imm    (r_imm),
        .o_result (w_aluResult),
`ifdef RF_ACCESS_CTRL_FLAGS_EN
        .o_carry  (w_aluCarry)
`else
        .o_carry  (w_unusedCarry)
`endif
    );

    // The read addresses double as the latched rs0/rs1 so they are stable from the first READ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_NOP;
            r_src0   <= '0;
            r_src1   <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_we     <= 1'b0;
            r_dst    <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
`ifdef RF_ACCESS_CTRL_FLAGS_EN
            r_zf     <= 1'b0;
            r_cf     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        r_op    <= opcode_t'(req.req_op);
                        r_src0  <= req.req_rs0;
                        r_src1  <= req.req_rs1;
                        r_rd    <= req.req_rd;
                        r_imm   <= req.req_imm;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_opA   <= rf.data0;
                    r_opB   <= rf.data1;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (writesBack(r_op)) begin
                        r_result <= w_aluResult;
                        r_data   <= w_aluResult;
`ifdef RF_ACCESS_CTRL_FLAGS_EN
                        r_zf     <= (w_aluResult == '0);
`endif
                    end
`ifdef RF_ACCESS_CTRL_FLAGS_EN
                    if (r_op == OP_ADD || r_op == OP_SUB) begin
                        r_cf <= w_aluCarry;
                    end
`endif
                    r_we    <= writesBack(r_op);
                    r_dst   <= r_rd;
                    r_done  <= 1'b1;
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req.req_ready = (r_state == ST_IDLE);
    assign req.done      = r_done;
    assign req.result    = r_result;
`ifdef RF_ACCESS_CTRL_FLAGS_EN
    assign req.zf        = r_zf;
    assign req.cf        = r_cf;
`endif

    assign rf.src0 = r_src0;
    assign rf.src1 = r_src1;
    assign rf.we   = r_we;
    assign rf.dst  = r_dst;
    assign rf.data = r_data;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: register-file environment, cycle-level reference model and directed tests.
// Flag checks are included when RF_ACCESS_CTRL_FLAGS_EN is defined.
module tb_rf_access_ctrl;
    import rf_access_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_req_if  reqIf ();
    rf_port_if portIf ();

    rf_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .req (reqIf.slave),
        .rf  (portIf.master)
    );

    // Register file the DUT talks to; poke* preloads it while the controller is idle.
    logic [7:0] envMem [32] = '{default: 8'h00};
    logic       pokeEn   = 1'b0;
    logic [4:0] pokeAddr = '0;
    logic [7:0] pokeData = '0;

    assign portIf.data0 = envMem[portIf.src0];
    assign portIf.data1 = envMem[portIf.src1];

    always @(posedge clk) begin
        if (portIf.we) envMem[portIf.dst] <= portIf.data;
        else if (pokeEn) envMem[pokeAddr] <= pokeData;
    end

    // Reference model: cycles since acceptance, result computed from the model's own register copy.
    logic [7:0] mMem [32] = '{default: 8'h00};
    int         busy = 0;
    logic [2:0] pOp = 3'd7;
    logic [4:0] pRs0 = '0, pRs1 = '0, pRd = '0;
    logic [7:0] pRes = '0;
    logic       pCarry = 1'b0;
    logic [7:0] expResult = '0;
    logic       expZf = 1'b0, expCf = 1'b0;

    always @(posedge clk or posedge rst) begin
        int a, b, wide;
        if (rst) begin
            busy = 0; expResult = '0; expZf = 1'b0; expCf = 1'b0;
        end else begin
            if (pokeEn) mMem[pokeAddr] = pokeData;
            if (busy == 3) begin
                if (pOp != 3'd7) mMem[pRd] = pRes;
                busy = 0;
            end else if (busy > 0) begin
                busy = busy + 1;
                if (busy == 3 && pOp != 3'd7) begin
                    expResult = pRes;
                    expZf = (pRes == 8'h00);
                    if (pOp == 3'd0 || pOp == 3'd1) expCf = pCarry;
                end
            end else if (reqIf.req_valid) begin
                pOp = reqIf.req_op; pRs0 = reqIf.req_rs0; pRs1 = reqIf.req_rs1; pRd = reqIf.req_rd;
                a = int'(mMem[pRs0]); b = int'(mMem[pRs1]);
                pCarry = 1'b0;
                case (pOp)
                    3'd0: begin wide = a + b; pRes = 8'(wide & 255); pCarry = (wide > 255); end
                    3'd1: begin wide = a - b; pRes = 8'(wide & 255); pCarry = (a < b); end
                    3'd2: pRes = 8'(a & b);
                    3'd3: pRes = 8'(a | b);
                    3'd4: pRes = 8'(a ^ b);
                    3'd5: pRes = 8'(a);
                    3'd6: pRes = reqIf.req_imm;
                    default: pRes = expResult;
                endcase
                busy = 1;
            end
        end
    end

    int compared = 0;
    int mismatched = 0;
    logic checkOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("req_ready", 32'(reqIf.req_ready), 32'(busy == 0));
            checkOutput("we", 32'(portIf.we), 32'(busy == 3 && pOp != 3'd7));
            checkOutput("done", 32'(reqIf.done), 32'(busy == 3));
            checkOutput("result", 32'(reqIf.result), 32'(expResult));
            if (busy == 3 && pOp != 3'd7) begin
                checkOutput("dst", 32'(portIf.dst), 32'(pRd));
                checkOutput("data", 32'(portIf.data), 32'(pRes));
            end
            if (busy == 1) begin
                checkOutput("src0", 32'(portIf.src0), 32'(pRs0));
                checkOutput("src1", 32'(portIf.src1), 32'(pRs1));
            end
`ifdef RF_ACCESS_CTRL_FLAGS_EN
            checkOutput("zf", 32'(reqIf.zf), 32'(expZf));
            checkOutput("cf", 32'(reqIf.cf), 32'(expCf));
`endif
        end
    end

    task automatic pokeReg(input logic [4:0] addr, input logic [7:0] val);
        pokeEn = 1'b1; pokeAddr = addr; pokeData = val;
        @(negedge clk);
        pokeEn = 1'b0;
    endtask

    // Called on a negedge while idle; returns one cycle later with req_valid low.
    task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rs0, input logic [4:0] rs1,
                                 input logic [4:0] rd, input logic [7:0] imm);
        reqIf.req_op = op; reqIf.req_rs0 = rs0; reqIf.req_rs1 = rs1;
        reqIf.req_rd = rd; reqIf.req_imm = imm; reqIf.req_valid = 1'b1;
        @(negedge clk);
        reqIf.req_valid = 1'b0;
    endtask

    task automatic runOp(input logic [2:0] op, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic [7:0] imm,
                         output logic we3, output logic done3, output logic [4:0] dst3,
                         output logic [7:0] data3, output int lowCycles);
        applyStimulus(op, rs0, rs1, rd, imm);
        lowCycles = 0;
        we3 = 1'b0; done3 = 1'b0; dst3 = '0; data3 = '0;
        for (int i = 0; i < 10 && !reqIf.req_ready; i++) begin
            lowCycles++;
            if (lowCycles == 3) begin
                we3 = portIf.we; done3 = reqIf.done; dst3 = portIf.dst; data3 = portIf.data;
            end
            @(negedge clk);
        end
    endtask

    logic       we3, done3;
    logic [4:0] dst3;
    logic [7:0] data3;
    int         lowCycles;

    initial begin
        reqIf.req_valid = 1'b0; reqIf.req_op = '0; reqIf.req_rs0 = '0;
        reqIf.req_rs1 = '0; reqIf.req_rd = '0; reqIf.req_imm = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst req_ready", 32'(reqIf.req_ready), 32'd1);
        checkOutput("rst we", 32'(portIf.we), 32'd0);
        checkOutput("rst done", 32'(reqIf.done), 32'd0);
        checkOutput("rst result", 32'(reqIf.result), 32'd0);
        checkOutput("rst dst", 32'(portIf.dst), 32'd0);
        checkOutput("rst data", 32'(portIf.data), 32'd0);
        checkOutput("rst src0", 32'(portIf.src0), 32'd0);
        checkOutput("rst src1", 32'(portIf.src1), 32'd0);
        rst = 1'b0;
        checkOn = 1'b1;

        // ADD r3 = r1 + r2
        pokeReg(5'd1, 8'h10);
        pokeReg(5'd2, 8'h05);
        runOp(3'd0, 5'd1, 5'd2, 5'd3, 8'h00, we3, done3, dst3, data3, lowCycles);
        checkOutput("add we", 32'(we3), 32'd1);
        checkOutput("add done", 32'(done3), 32'd1);
        checkOutput("add dst", 32'(dst3), 32'd3);
        checkOutput("add data", 32'(data3), 32'h15);
        checkOutput("add ready low", 32'(lowCycles), 32'd3);
        checkOutput("add r3", 32'(envMem[3]), 32'h15);

        // SUB wraps to 0xFF with borrow
        pokeReg(5'd1, 8'h00);
        pokeReg(5'd2, 8'h01);
        runOp(3'd1, 5'd1, 5'd2, 5'd1, 8'h00, we3, done3, dst3, data3, lowCycles);
        checkOutput("sub data", 32'(data3), 32'hFF);
        checkOutput("sub r1", 32'(envMem[1]), 32'hFF);
`ifdef RF_ACCESS_CTRL_FLAGS_EN
        checkOutput("sub cf", 32'(reqIf.cf), 32'd1);
        checkOutput("sub zf", 32'(reqIf.zf), 32'd0);
`endif

        // LDI into r0, then MOV r7 = r0 back-to-back
        runOp(3'd6, 5'd0, 5'd0, 5'd0, 8'hA5, we3, done3, dst3, data3, lowCycles);
        checkOutput("ldi dst", 32'(dst3), 32'd0);
        checkOutput("ldi data", 32'(data3), 32'hA5);
        checkOutput("ldi ready low", 32'(lowCycles), 32'd3);
        runOp(3'd5, 5'd0, 5'd0, 5'd7, 8'h00, we3, done3, dst3, data3, lowCycles);
        checkOutput("mov ready low", 32'(lowCycles), 32'd3);
        checkOutput("mov r7", 32'(envMem[7]), 32'hA5);

        // NOP with req_valid toggled while busy
        applyStimulus(3'd7, 5'd1, 5'd2, 5'd5, 8'h00);
        reqIf.req_op = 3'd0; reqIf.req_rd = 5'd5; reqIf.req_valid = 1'b1;
        @(negedge clk);
        reqIf.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("nop we", 32'(portIf.we), 32'd0);
        checkOutput("nop done", 32'(reqIf.done), 32'd1);
        reqIf.req_valid = 1'b1;
        @(negedge clk);
        reqIf.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("nop no extra op", 32'(reqIf.req_ready), 32'd1);
        checkOutput("nop result held", 32'(reqIf.result), 32'hA5);
        checkOutput("nop r5 untouched", 32'(envMem[5]), 32'h00);

        // Reset during EXEC of XOR r4
        pokeReg(5'd1, 8'h0F);
        pokeReg(5'd2, 8'hF0);
        pokeReg(5'd4, 8'h3C);
        applyStimulus(3'd4, 5'd1, 5'd2, 5'd4, 8'h00);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid rst req_ready", 32'(reqIf.req_ready), 32'd1);
        checkOutput("mid rst we", 32'(portIf.we), 32'd0);
        checkOutput("mid rst done", 32'(reqIf.done), 32'd0);
        checkOutput("mid rst result", 32'(reqIf.result), 32'd0);
        checkOutput("mid rst dst", 32'(portIf.dst), 32'd0);
        checkOutput("mid rst data", 32'(portIf.data), 32'd0);
        checkOutput("mid rst src0", 32'(portIf.src0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("mid rst r4", 32'(envMem[4]), 32'h3C);

        // Same-register ADD r2 = r2 + r2
        pokeReg(5'd2, 8'h80);
        runOp(3'd0, 5'd2, 5'd2, 5'd2, 8'h00, we3, done3, dst3, data3, lowCycles);
        checkOutput("same we", 32'(we3), 32'd1);
        checkOutput("same data", 32'(data3), 32'h00);
        checkOutput("same r2", 32'(envMem[2]), 32'h00);
`ifdef RF_ACCESS_CTRL_FLAGS_EN
        checkOutput("same zf", 32'(reqIf.zf), 32'd1);
        checkOutput("same cf", 32'(reqIf.cf), 32'd1);
`endif

        repeat (2) @(negedge clk);
        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
